pipe_addsub: RTL
================

// Module: pipe_addsub
// PURPOSE
//  Parametrised, pipelined add/subtract unit for the datapath.
//  Splits a WIDTH-bit add/sub into SEG-bit segments, one segment per stage, carry registered between stages.
//  Adds valid/ready handshake, carry-in, signed saturation and status flags (carry, overflow, zero, negative).
//  Sits between operand registers and the writeback mux; replaces wide combinational ripple adders on timing-critical paths.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of SEG (elaboration error otherwise)
//  SEG     8  bits added per pipeline stage; STAGES = WIDTH/SEG (1 = single registered stage)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      1 = A - B, 0 = A + B
//  sat        in   1      1 = clamp result to signed range on overflow
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  s          out  WIDTH  result
//  co         out  1      raw carry out of MSB (sub: 1 = no borrow)
//  ov         out  1      signed overflow (before saturation)
//  zf         out  1      s == 0 (after saturation)
//  nf         out  1      s[WIDTH-1] (after saturation)
// BEHAVIOUR
//  - Arithmetic: bx = b ^ {WIDTH{sub}}, cix = ci ^ sub; sum = a + bx + cix, modulo 2^WIDTH.
//    sub=1, ci=0 -> a-b; sub=1, ci=1 -> a-b-1 (borrow-in).
//  - ov = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
//  - sat=1 and ov=1: s = a[MSB] ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}. Otherwise s = sum.
//    co, ov always reflect the unsaturated sum.
//  - Pipeline: STAGES register stages. Stage k (1..STAGES) holds:
//    valid bit, sum segments 0..k-1, registered carry out of segment k-1, unconsumed a/bx segments, sub/sat/MSB info.
//    Stage 1 computes segment 0 from inputs using cix; stage k+1 computes segment k from stage k's carry.
//  - Flags and saturation are computed combinationally from the final stage register; no extra latency.
//  - Latency: beat accepted on edge N (in_valid && in_ready) -> out_valid high after edge N+STAGES-1
//    (single beat: out_valid visible STAGES cycles after acceptance cycle), when no stall occurs.
//  - Handshake: en = !out_valid || out_ready; in_ready = en. All stages advance together when en=1; all hold when en=0.
//    Bubbles are not collapsed. Throughput: 1 beat/cycle when out_ready held high.
//  - Inputs sampled only when in_valid && in_ready. While out_valid && !out_ready: s/co/ov/zf/nf held stable.
//  - in_valid=0 while en=1 inserts a bubble (stage valid=0). Output data is don't-care when out_valid=0.
//  - Reset: all stage valid bits, carries and data registers cleared. After reset: out_valid=0, s=0, co=0, ov=0, nf=0, zf=1.
//    in_ready=1 in the first cycle after reset.
//    Reset mid-operation discards all in-flight beats; nothing emerges afterwards.
//  - Simultaneous accept and emit in one cycle is legal and required for full throughput.
//  - Width edge cases: SEG == WIDTH gives STAGES=1, latency 1. WIDTH=1 is legal (s=a^bx^cix).
// TESTING  (WIDTH=8, SEG=4 unless noted; latency 2)
//  1. Add 0x7F+0x01, ci=0, sat=0 -> s=0x80, co=0, ov=1, nf=1, zf=0; with sat=1 -> s=0x7F, ov=1.
//  2. Sub 0x00-0x01, ci=0 -> s=0xFF, co=0, ov=0. Sub 0x80-0x01, sat=1 -> ov=1, s=0x80.
//     Sub 0x05-0x05 -> s=0x00, co=1, zf=1.
//  3. Add 0xFF+0x01 -> s=0x00, co=1, zf=1, ov=0; carry crosses segment boundary via the stage-1 carry register.
//  4. Stream 16 random beats back-to-back with out_ready=1 -> one result per cycle, in order, each 2 cycles after accept;
//     compare against the a+bx+cix model.
//  5. Hold out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs stable.
//     Release -> no beat lost or duplicated.
//  6. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beat emerges.
//     Repeat test 4 with WIDTH=32, SEG=8 and with SEG=WIDTH.

Source files
------------

// File: rtl/pipe_addsub_if.sv
// Operand/result bundle for pipe_addsub: operand beat with valid/ready in, result beat with flags out.
interface pipe_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ov;
   logic             zf;
   logic             nf;

   modport master (
      output in_valid, a, b, ci, sub, sat, out_ready,
      input  in_ready, out_valid, s, co, ov, zf, nf
   );

   modport slave (
      input  in_valid, a, b, ci, sub, sat, out_ready,
      output in_ready, out_valid, s, co, ov, zf, nf
   );
endinterface

// File: rtl/pipe_addsub.sv
// Segmented add/sub, one SEG-bit slice per stage with the carry registered between stages; latency WIDTH/SEG cycles.
// Backpressure: every stage holds while a result waits unconsumed; in_ready = !out_valid || out_ready.
module pipe_addsub #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input logic          clk,
   input logic          rst,
   pipe_addsub_if.slave bus
);
   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_seg
      $error("pipe_addsub: WIDTH must be a positive multiple of SEG");
   end

   if ($bits(bus.a) != WIDTH) begin : g_bad_if
      $error("pipe_addsub: interface WIDTH does not match module WIDTH");
   end

   logic             en;
   logic [WIDTH-1:0] bx_in;
   logic             cix_in;

   logic             st_vld [STAGES];
   logic             st_cy  [STAGES];
   logic             st_sat [STAGES];
   logic [WIDTH-1:0] st_sum [STAGES];
   logic [WIDTH-1:0] st_a   [STAGES];
   logic [WIDTH-1:0] st_bx  [STAGES];

   logic [SEG:0]     seg_res [STAGES];
   logic [WIDTH-1:0] nxt_sum [STAGES];

   logic [WIDTH-1:0] fin_sum;
   logic [WIDTH-1:0] sat_val;
   logic [WIDTH-1:0] res;
   logic             a_msb;
   logic             bx_msb;
   logic             ovf;

   // Slice k is added in stage k+1; slice 0 comes straight from the operand bus.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         seg_res[k] = '0;
         nxt_sum[k] = '0;
      end
      bx_in  = bus.b ^ {WIDTH{bus.sub}};
      cix_in = bus.ci ^ bus.sub;

      seg_res[0] = {1'b0, bus.a[SEG-1:0]} + {1'b0, bx_in[SEG-1:0]} + {{SEG{1'b0}}, cix_in};
      nxt_sum[0][SEG-1:0] = seg_res[0][SEG-1:0];

      for (int k = 1; k < STAGES; k++) begin
         seg_res[k] = {1'b0, st_a[k-1][k*SEG +: SEG]}
                    + {1'b0, st_bx[k-1][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, st_cy[k-1]};
         nxt_sum[k] = st_sum[k-1];
         nxt_sum[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            st_vld[k] <= 1'b0;
            st_cy[k]  <= 1'b0;
            st_sat[k] <= 1'b0;
            st_sum[k] <= '0;
            st_a[k]   <= '0;
            st_bx[k]  <= '0;
         end
      end else if (en) begin
         st_vld[0] <= bus.in_valid;
         if (bus.in_valid) begin
            st_sum[0] <= nxt_sum[0];
            st_cy[0]  <= seg_res[0][SEG];
            st_a[0]   <= bus.a;
            st_bx[0]  <= bx_in;
            st_sat[0] <= bus.sat;
         end
         // Bubbles travel with the stream; no stage is skipped or collapsed.
         for (int k = 1; k < STAGES; k++) begin
            st_vld[k] <= st_vld[k-1];
            st_sum[k] <= nxt_sum[k];
            st_cy[k]  <= seg_res[k][SEG];
            st_a[k]   <= st_a[k-1];
            st_bx[k]  <= st_bx[k-1];
            st_sat[k] <= st_sat[k-1];
         end
      end
   end

   assign fin_sum = st_sum[LAST];
   assign a_msb   = st_a[LAST][WIDTH-1];
   assign bx_msb  = st_bx[LAST][WIDTH-1];
   assign ovf     = (a_msb == bx_msb) && (fin_sum[WIDTH-1] != a_msb);

   // Clamp toward the sign of A: negative overflow saturates to min, positive to max.
   always_comb begin
      sat_val            = {WIDTH{~a_msb}};
      sat_val[WIDTH-1]   = a_msb;
      res                = (st_sat[LAST] && ovf) ? sat_val : fin_sum;
   end

   assign en            = !st_vld[LAST] || bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = st_vld[LAST];
   assign bus.s         = res;
   assign bus.co        = st_cy[LAST];
   assign bus.ov        = ovf;
   assign bus.zf        = (res == '0);
   assign bus.nf        = res[WIDTH-1];
endmodule
